// File: rtl/discrete_sys_inv_pkg.sv
// rtl/discrete_sys_inv_pkg.sv - shared widths, constants and FSM states for discrete_sys_inv
package discrete_sys_inv_pkg;

    localparam logic [3:0] M_DEFAULT  = 4'd15;
    localparam int         DIN_W      = 20;
    localparam int         V_W        = 24;
    localparam int         X_W        = 14;
    localparam int         DOUT_W     = 8;
    localparam int         DIV_CYCLES = 24;
    localparam int         CNT_W      = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DIV,
        ST_OUT
    } state_e;

endpackage

// File: rtl/seq_div_const.sv
// rtl/seq_div_const.sv - restoring divider, one quotient bit per cycle, 4-bit divisor
module seq_div_const
    import discrete_sys_inv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [V_W-1:0]   dividend_i,
    input  logic [3:0]       divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [X_W-1:0]   quotient_o,
    output logic [3:0]       remainder_o
);

    // quo_q starts as the dividend; its MSBs shift out into the partial
    // remainder while quotient bits shift in at the LSB end.
    logic [V_W-1:0]   quo_q, quo_d;
    logic [3:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       trial;

    // One restoring step per cycle while busy; load a new dividend when idle
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        trial = {rem_q, quo_q[V_W-1]};
        if (cnt_q != '0) begin
            if (trial >= {1'b0, divisor_i}) begin
                // difference is below the divisor, so it fits in 4 bits
                rem_d = trial[3:0] - divisor_i;
                quo_d = {quo_q[V_W-2:0], 1'b1};
            end else begin
                rem_d = trial[3:0];
                quo_d = {quo_q[V_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
        end else if (start_i) begin
            quo_d = dividend_i;
            rem_d = '0;
            cnt_d = CNT_W'(DIV_CYCLES);
        end
    end

    // Divider state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

    assign busy_o      = (cnt_q != '0);
    // High in the cycle whose closing edge writes the final quotient bit
    assign done_o      = (cnt_q == CNT_W'(1));
    // Recovered x wraps modulo 2^14, so only the low quotient bits matter
    assign quotient_o  = quo_q[X_W-1:0];
    assign remainder_o = rem_q;

endmodule

// File: rtl/discrete_sys_inv.sv
// rtl/discrete_sys_inv.sv - sample-serial inverse of the M-weighted cascaded sum system
module discrete_sys_inv
    import discrete_sys_inv_pkg::*;
#(
    parameter logic [3:0] M = M_DEFAULT
)
(
    input  logic              clk_21,
    input  logic              rst_21,
    input  logic              data_valid_21,
    input  logic [DIN_W-1:0]  din_21,
    output logic              ready_21,
    output logic              dout_valid_21,
    output logic [DOUT_W-1:0] dout_21,
    output logic              err_21
);

    localparam logic [V_W-1:0] M_V = V_W'(M);

    state_e              state_q, state_d;
    logic [DIN_W-1:0]    din_q;
    logic [V_W-1:0]      v_q, v1_q, v2_q;
    logic [X_W-1:0]      x1_q, x2_q;
    logic [DOUT_W-1:0]   dout_q;
    logic                dout_valid_q;
    logic                err_q;

    logic [V_W-1:0]      v_calc;
    logic [V_W-1:0]      v_abs;
    logic [X_W-1:0]      s_calc;
    logic [X_W-1:0]      x_calc;
    logic                x_range_err;
    logic [DOUT_W-1:0]   dout_sat;

    logic                div_start;
    logic                div_busy;
    logic                div_done;
    logic [X_W-1:0]      div_quo;
    logic [3:0]          div_rem;

    // Datapath: undo the outer M-weighted recursion, then the inner sum
    always_comb begin
        v_calc      = {{(V_W-DIN_W){1'b0}}, din_q} - M_V * v1_q - M_V * v2_q;
        v_abs       = v_calc[V_W-1] ? (~v_calc + 1'b1) : v_calc;
        s_calc      = v_q[V_W-1] ? (~div_quo + 1'b1) : div_quo;
        x_calc      = s_calc - x1_q - x2_q;
        x_range_err = x_calc[X_W-1] || (|x_calc[X_W-2:DOUT_W]);
        if (x_calc[X_W-1]) begin
            dout_sat = '0;
        end else if (x_range_err) begin
            dout_sat = '1;
        end else begin
            dout_sat = x_calc[DOUT_W-1:0];
        end
    end

    // Next-state logic; the divider is launched from CALC with |v|
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: if (data_valid_21) state_d = ST_CALC;
            ST_CALC: begin
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
            // an idle divider in DIV can only mean it already finished
            ST_DIV:  if (div_done || !div_busy) state_d = ST_OUT;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_21 or posedge rst_21) begin
        if (rst_21) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample capture, v register, history shift and output registers
    always_ff @(posedge clk_21 or posedge rst_21) begin
        if (rst_21) begin
            din_q        <= '0;
            v_q          <= '0;
            v1_q         <= '0;
            v2_q         <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            dout_valid_q <= (state_q == ST_OUT);
            if (state_q == ST_IDLE && data_valid_21) begin
                din_q <= din_21;
            end
            if (state_q == ST_CALC) begin
                v_q <= v_calc;
            end
            if (state_q == ST_OUT) begin
                v2_q   <= v1_q;
                v1_q   <= v_q;
                x2_q   <= x1_q;
                x1_q   <= x_calc;
                dout_q <= dout_sat;
                if (div_rem != 4'd0 || x_range_err) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    seq_div_const u_div (
        .clk_i       (clk_21),
        .rst_i       (rst_21),
        .start_i     (div_start),
        .dividend_i  (v_abs),
        .divisor_i   (M),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign ready_21      = (state_q == ST_IDLE);
    assign dout_valid_21 = dout_valid_q;
    assign dout_21       = dout_q;
    assign err_21        = err_q;

endmodule

// File: tb/tb_discrete_sys_inv.sv
// tb/tb_discrete_sys_inv.sv - randomized self-checking bench for discrete_sys_inv
module tb_discrete_sys_inv;

    localparam logic [3:0] M  = 4'd15;
    localparam int         MI = 15;

    logic        clk_21 = 1'b0;
    logic        rst_21 = 1'b0;
    logic        data_valid_21 = 1'b0;
    logic [19:0] din_21 = '0;
    logic        ready_21;
    logic        dout_valid_21;
    logic [7:0]  dout_21;
    logic        err_21;

    discrete_sys_inv #(.M(M)) dut (
        .clk_21        (clk_21),
        .rst_21        (rst_21),
        .data_valid_21 (data_valid_21),
        .din_21        (din_21),
        .ready_21      (ready_21),
        .dout_valid_21 (dout_valid_21),
        .dout_21       (dout_21),
        .err_21        (err_21)
    );

    always #5 clk_21 = ~clk_21;

    int checks = 0;
    int errors = 0;

    // reference model state
    longint mv1, mv2, mx1, mx2;
    int     mcnt;
    bit     mvalid;
    int     mdout;
    bit     merr;
    int     pend_dout;
    bit     pend_err;

    // observations at the modelled output pulse
    bit     pulse_seen;
    int     pulse_dout;
    int     pulse_err;
    int     last_lat;
    int     dut_pulses;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint a, input int w);
        longint m;
        m = (longint'(1) << w);
        a = a & (m - 1);
        if (a >= (m >> 1)) a = a - m;
        return a;
    endfunction

    task automatic model_reset();
        mv1 = 0; mv2 = 0; mx1 = 0; mx2 = 0;
        mcnt = 0; mvalid = 0; mdout = 0; merr = 0;
        pend_dout = 0; pend_err = 0;
    endtask

    // Invert the forward system with plain signed integer arithmetic
    task automatic model_accept(input logic [19:0] d);
        longint v, s, r, x;
        v = sx(longint'(d) - MI * mv1 - MI * mv2, 24);
        s = v / MI;
        r = v % MI;
        x = sx(s - mx1 - mx2, 14);
        pend_dout = (x < 0) ? 0 : (x > 255) ? 255 : int'(x);
        pend_err  = (r != 0) || (x < 0) || (x > 255);
        mv2 = mv1; mv1 = v;
        mx2 = mx1; mx1 = x;
        mcnt = 27;
    endtask

    // Called at a falling edge: compare this cycle, drive inputs, advance one cycle
    task automatic step(input bit v, input logic [19:0] d);
        if (mcnt > 0) begin
            mcnt--;
            mvalid = (mcnt == 0);
        end else begin
            mvalid = 0;
        end
        if (mvalid) begin
            mdout = pend_dout;
            merr  = merr | pend_err;
        end
        chk("ready", ready_21, int'(mcnt == 0));
        chk("dout_valid", dout_valid_21, int'(mvalid));
        chk("dout", dout_21, mdout);
        chk("err", err_21, int'(merr));
        if (dout_valid_21 === 1'b1) dut_pulses++;
        if (mvalid) begin
            pulse_seen = 1;
            pulse_dout = int'(dout_21);
            pulse_err  = int'(err_21);
        end
        data_valid_21 = v;
        din_21        = d;
        if (v && mcnt == 0) model_accept(d);
        @(posedge clk_21);
        @(negedge clk_21);
    endtask

    task automatic do_reset();
        data_valid_21 = 1'b0;
        rst_21 = 1'b1;
        #1;
        model_reset();
        chk("rst_ready", ready_21, 1);
        chk("rst_dout_valid", dout_valid_21, 0);
        chk("rst_dout", dout_21, 0);
        chk("rst_err", err_21, 0);
        @(posedge clk_21);
        @(negedge clk_21);
        rst_21 = 1'b0;
    endtask

    task automatic send(input logic [19:0] d);
        int n;
        n = 0;
        while (mcnt != 0 && n < 60) begin
            step(0, '0);
            n++;
        end
        pulse_seen = 0;
        step(1, d);
        n = 0;
        while (!pulse_seen && n < 60) begin
            step(0, '0);
            n++;
        end
        last_lat = n;
        if (!pulse_seen) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: no output pulse for d=%0d", d);
        end
    endtask

    initial begin
        #2;
        do_reset();

        // x = 10, 0, 0
        send(20'd150);
        chk("x10_dout", pulse_dout, 10);
        chk("x10_err", pulse_err, 0);
        chk("x10_latency", last_lat, 27);
        send(20'd2400);
        chk("x0a_dout", pulse_dout, 0);
        send(20'd4650);
        chk("x0b_dout", pulse_dout, 0);
        chk("x0b_err", pulse_err, 0);

        // top of range
        do_reset();
        send(20'd3825);
        chk("x255_dout", pulse_dout, 255);
        chk("x255_err", pulse_err, 0);

        // inexact division sets a sticky error
        do_reset();
        send(20'd7);
        chk("d7_dout", pulse_dout, 0);
        chk("d7_err", pulse_err, 1);
        for (int i = 0; i < 10; i++) send(20'($urandom_range(0, 5000)));
        chk("err_sticky", err_21, 1);

        // valid held high: one acceptance per 27 cycles
        do_reset();
        dut_pulses = 0;
        for (int i = 0; i < 270; i++) step(1, 20'($urandom));
        chk("held_valid_pulses", dut_pulses, 9);

        // reset during DIV discards the sample
        do_reset();
        step(1, 20'd150);
        for (int i = 0; i < 11; i++) step(0, '0);
        do_reset();
        dut_pulses = 0;
        for (int i = 0; i < 30; i++) step(0, '0);
        chk("no_pulse_after_abort", dut_pulses, 0);
        send(20'd150);
        chk("abort_then_x10", pulse_dout, 10);

        // random traffic: sparse valids, mixed small and full-range samples
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [19:0] d;
            d = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 4000)) : 20'($urandom);
            step($urandom_range(0, 3) == 0, d);
        end
        for (int i = 0; i < 30; i++) step(0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
